rx232_pd_gen: RTL and testbench



---
 rtl/rx232_pkg.sv | 21 ++
 rtl/rx232_edge_det.sv | 18 +
 rtl/rx232_pd_gen.sv | 134 +++++++++++++
 tb/tb_rx232_pd_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx232_pkg.sv
// Shared types and constants for the parametrised RS-232 receive path.
package rx232_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BRK    = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Required XOR of data and parity bit: 1 for odd, 0 for even.
  function automatic logic parity_expected(input int mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/rx232_edge_det.sv
// Bit-clock delay line producing a one-clk pulse per rising edge of rxck.
module rx232_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic rxck,
  output logic rxck_r
);

  logic [1:0] d;

  always_ff @(posedge clk) begin
    if (!rst) d <= '0;
    else      d <= {d[0], rxck};
  end

  assign rxck_r = d[0] & ~d[1];

endmodule

// File: rtl/rx232_pd_gen.sv
// RS-232 receive deserialiser: 5..9 data bits, optional parity, 1/2 stop bits.
// Define RX232_BREAK_DET_EN to enable break detection (BRK state, break_det).
module rx232_pd_gen
  import rx232_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxsdi,
  input  logic                 rxck,
  output logic [DATA_BITS-1:0] rxpd,
  output logic                 rx_vld,
  input  logic                 rx_ack,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_start,
  output logic                 rx_busy,
  output logic                 overrun_err,
  output logic                 break_det
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam bit         HAS_PAR  = (PARITY_MODE != PAR_NONE);

  rx_state_t            state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_cnt;
  logic                 ferr_acc;
  logic                 rxck_r;

  rx232_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .rxck   (rxck),
    .rxck_r (rxck_r)
  );

  logic last_stop, frame_ferr, frame_perr, brk_take;

  assign last_stop  = (STOP_BITS == 1) || stop_cnt;
  assign frame_ferr = ferr_acc | ~rxsdi;
  assign frame_perr = HAS_PAR && ((^shreg ^ par_bit) != parity_expected(PARITY_MODE));
  assign rx_busy    = (state != IDLE);

`ifdef RX232_BREAK_DET_EN
  // Break is judged on the first stop sample, before any second stop bit.
  assign brk_take = !stop_cnt && (shreg == '0) && (!HAS_PAR || !par_bit) && !rxsdi;
`else
  assign brk_take  = 1'b0;
  assign break_det = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      stop_cnt    <= 1'b0;
      ferr_acc    <= 1'b0;
      rxpd        <= '1;
      rx_vld      <= 1'b0;
      rx_perr     <= 1'b0;
      rx_ferr     <= 1'b0;
      rx_start    <= 1'b0;
      overrun_err <= 1'b0;
`ifdef RX232_BREAK_DET_EN
      break_det   <= 1'b0;
`endif
    end else begin
      rx_start    <= 1'b0;
      overrun_err <= 1'b0;
`ifdef RX232_BREAK_DET_EN
      break_det   <= 1'b0;
`endif
      if (rx_vld && rx_ack) rx_vld <= 1'b0;

      if (rxck_r) begin
        case (state)
          IDLE: begin
            if (!rxsdi) begin
              state    <= DATA;
              bit_cnt  <= '0;
              rx_start <= 1'b1;
            end
          end
          DATA: begin
            shreg    <= {rxsdi, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            if (bit_cnt == LAST_BIT) state <= HAS_PAR ? PARITY : STOP;
          end
          PARITY: begin
            par_bit <= rxsdi;
            state   <= STOP;
          end
          STOP: begin
            if (brk_take) begin
`ifdef RX232_BREAK_DET_EN
              break_det <= 1'b1;
`endif
              state <= BRK;
            end else if (!last_stop) begin
              stop_cnt <= 1'b1;
              ferr_acc <= ~rxsdi;
            end else begin
              state <= IDLE;
              // A held, unacknowledged word wins over the new one.
              if (!rx_vld || rx_ack) begin
                rxpd    <= shreg;
                rx_perr <= frame_perr;
                rx_ferr <= frame_ferr;
                rx_vld  <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end
          end
          BRK: begin
            if (rxsdi) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx232_pd_gen.sv
// Directed bench for rx232_pd_gen; four configurations share one serial stream.
module tb_rx232_pd_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxsdi = 1'b1;
  logic rxck = 1'b0;
  logic rx_ack = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // 8N1
  logic [7:0] a_pd; logic a_vld, a_perr, a_ferr, a_start, a_busy, a_ovr, a_brk;
  // 8E1
  logic [7:0] e_pd; logic e_vld, e_perr, e_ferr, e_start, e_busy, e_ovr, e_brk;
  // 8N2
  logic [7:0] s_pd; logic s_vld, s_perr, s_ferr, s_start, s_busy, s_ovr, s_brk;
  // 5N1
  logic [4:0] f_pd; logic f_vld, f_perr, f_ferr, f_start, f_busy, f_ovr, f_brk;

  rx232_pd_gen #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rxsdi(rxsdi), .rxck(rxck), .rxpd(a_pd), .rx_vld(a_vld),
    .rx_ack(rx_ack), .rx_perr(a_perr), .rx_ferr(a_ferr), .rx_start(a_start),
    .rx_busy(a_busy), .overrun_err(a_ovr), .break_det(a_brk));

  rx232_pd_gen #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .rxsdi(rxsdi), .rxck(rxck), .rxpd(e_pd), .rx_vld(e_vld),
    .rx_ack(rx_ack), .rx_perr(e_perr), .rx_ferr(e_ferr), .rx_start(e_start),
    .rx_busy(e_busy), .overrun_err(e_ovr), .break_det(e_brk));

  rx232_pd_gen #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_s (
    .clk(clk), .rst(rst), .rxsdi(rxsdi), .rxck(rxck), .rxpd(s_pd), .rx_vld(s_vld),
    .rx_ack(rx_ack), .rx_perr(s_perr), .rx_ferr(s_ferr), .rx_start(s_start),
    .rx_busy(s_busy), .overrun_err(s_ovr), .break_det(s_brk));

  rx232_pd_gen #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1)) u_f (
    .clk(clk), .rst(rst), .rxsdi(rxsdi), .rxck(rxck), .rxpd(f_pd), .rx_vld(f_vld),
    .rx_ack(rx_ack), .rx_perr(f_perr), .rx_ferr(f_ferr), .rx_start(f_start),
    .rx_busy(f_busy), .overrun_err(f_ovr), .break_det(f_brk));

  // One bit time: the DUT acts on the posedge just before this task returns,
  // and ack (if requested) is high only on that edge.
  task automatic tick(input logic b, input logic ack);
    rxsdi = b;
    rxck  = 1'b1;
    @(negedge clk);
    rx_ack = ack;
    rxck   = 1'b0;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [8:0] d, input logic has_par,
                            input logic pb, input int nstop, input logic s1,
                            input logic s2, input logic ack_last);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) q.push_back(d[i]);
    if (has_par) q.push_back(pb);
    q.push_back(s1);
    if (nstop == 2) q.push_back(s2);
    for (int i = 0; i < q.size(); i++) tick(q[i], ack_last && (i == q.size() - 1));
    tick(1'b1, 1'b0);  // idle gap; the DUT is back in IDLE so nothing changes
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rxck = 1'b0; rxsdi = 1'b1; rx_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_pd !== 8'hFF || a_vld !== 1'b0 || a_perr !== 1'b0 || a_ferr !== 1'b0) begin
      errors++; $display("FAIL reset_8n1 pd=%h vld=%b perr=%b ferr=%b want ff/0/0/0", a_pd, a_vld, a_perr, a_ferr);
    end
    checks++;
    if (a_start !== 1'b0 || a_busy !== 1'b0 || a_ovr !== 1'b0 || a_brk !== 1'b0) begin
      errors++; $display("FAIL reset_pulses start=%b busy=%b ovr=%b brk=%b want 0", a_start, a_busy, a_ovr, a_brk);
    end
    checks++;
    if (f_pd !== 5'h1F || f_vld !== 1'b0) begin
      errors++; $display("FAIL reset_5bit pd=%h vld=%b want 1f/0", f_pd, f_vld);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    do_reset();
    tick(1'b0, 1'b0);
    checks++;
    if (a_start !== 1'b1 || a_busy !== 1'b1) begin
      errors++; $display("FAIL start_pulse start=%b busy=%b want 1/1", a_start, a_busy);
    end
    tick(d[0], 1'b0);
    checks++;
    if (a_start !== 1'b0) begin
      errors++; $display("FAIL start_one_clk start=%b want 0", a_start);
    end
    for (int i = 1; i < 8; i++) tick(d[i], 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (a_pd !== 8'hA5 || a_vld !== 1'b1 || a_perr !== 1'b0 || a_ferr !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL frame_a5 pd=%h vld=%b perr=%b ferr=%b busy=%b want a5/1/0/0/0",
                         a_pd, a_vld, a_perr, a_ferr, a_busy);
    end
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    checks++;
    if (a_vld !== 1'b0 || a_pd !== 8'hA5) begin
      errors++; $display("FAIL ack_clears vld=%b pd=%h want 0/a5", a_vld, a_pd);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8, 9'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (e_pd !== 8'h07 || e_vld !== 1'b1 || e_perr !== 1'b1 || e_ferr !== 1'b0) begin
      errors++; $display("FAIL even_par_bad pd=%h vld=%b perr=%b ferr=%b want 07/1/1/0", e_pd, e_vld, e_perr, e_ferr);
    end
    do_reset();
    send_frame(8, 9'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (e_pd !== 8'h07 || e_perr !== 1'b0) begin
      errors++; $display("FAIL even_par_good pd=%h perr=%b want 07/0", e_pd, e_perr);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_frame(8, 9'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_pd !== 8'h3C || s_vld !== 1'b1 || s_ferr !== 1'b1 || s_perr !== 1'b0) begin
      errors++; $display("FAIL stop2_ferr pd=%h vld=%b ferr=%b perr=%b want 3c/1/1/0", s_pd, s_vld, s_ferr, s_perr);
    end
    do_reset();
    send_frame(8, 9'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_pd !== 8'h3C || s_ferr !== 1'b0) begin
      errors++; $display("FAIL stop2_ok pd=%h ferr=%b want 3c/0", s_pd, s_ferr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8, 9'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    // second frame without the idle gap so the overrun pulse can be sampled
    tick(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(((9'h22 >> i) & 9'h1) != 0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (a_ovr !== 1'b1 || a_pd !== 8'h11 || a_vld !== 1'b1) begin
      errors++; $display("FAIL overrun ovr=%b pd=%h vld=%b want 1/11/1", a_ovr, a_pd, a_vld);
    end
    @(negedge clk);
    checks++;
    if (a_ovr !== 1'b0) begin
      errors++; $display("FAIL overrun_one_clk ovr=%b want 0", a_ovr);
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(((9'h22 >> i) & 9'h1) != 0, 1'b0);
    tick(1'b1, 1'b1);
    checks++;
    if (a_ovr !== 1'b0 || a_pd !== 8'h22 || a_vld !== 1'b1) begin
      errors++; $display("FAIL ack_on_done ovr=%b pd=%h vld=%b want 0/22/1", a_ovr, a_pd, a_vld);
    end
  endtask

  task automatic test_break();
    int brk_cnt;
    int vld_seen;
    int ovr_cnt;
    brk_cnt = 0; vld_seen = 0; ovr_cnt = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      if (a_brk === 1'b1) brk_cnt++;
      if (a_vld === 1'b1) vld_seen++;
      if (a_ovr === 1'b1) ovr_cnt++;
    end
    tick(1'b1, 1'b0);
    if (a_brk === 1'b1) brk_cnt++;
`ifdef RX232_BREAK_DET_EN
    checks++;
    if (brk_cnt !== 1 || vld_seen !== 0 || a_busy !== 1'b0 || a_pd !== 8'hFF) begin
      errors++; $display("FAIL break_det pulses=%0d vld_cycles=%0d busy=%b pd=%h want 1/0/0/ff",
                         brk_cnt, vld_seen, a_busy, a_pd);
    end
    send_frame(8, 9'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_pd !== 8'h5A || a_vld !== 1'b1 || a_ferr !== 1'b0) begin
      errors++; $display("FAIL after_break pd=%h vld=%b ferr=%b want 5a/1/0", a_pd, a_vld, a_ferr);
    end
`else
    checks++;
    if (brk_cnt !== 0 || a_pd !== 8'h00 || a_vld !== 1'b1 || a_ferr !== 1'b0 + 1'b1 || a_perr !== 1'b0) begin
      errors++; $display("FAIL zero_frame pulses=%0d pd=%h vld=%b ferr=%b perr=%b want 0/00/1/1/0",
                         brk_cnt, a_pd, a_vld, a_ferr, a_perr);
    end
    // ticks 11..20 form a second all-zero frame that overruns the first
    checks++;
    if (ovr_cnt !== 1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL zero_overrun ovr_pulses=%0d busy=%b want 1/0", ovr_cnt, a_busy);
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic [4:0] d;
    d = 5'h15;
    do_reset();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(d[i], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (f_pd !== 5'h1F || f_vld !== 1'b0 || f_busy !== 1'b0 || f_start !== 1'b0 ||
        f_perr !== 1'b0 || f_ferr !== 1'b0 || f_ovr !== 1'b0 || f_brk !== 1'b0) begin
      errors++; $display("FAIL mid_reset pd=%h vld=%b busy=%b want 1f/0/0", f_pd, f_vld, f_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    send_frame(5, 9'h0A, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (f_pd !== 5'h0A || f_vld !== 1'b1 || f_ferr !== 1'b0 || f_perr !== 1'b0) begin
      errors++; $display("FAIL post_reset_5bit pd=%h vld=%b ferr=%b want 0a/1/0", f_pd, f_vld, f_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_break();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
